// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: cause codes, mstatus
// fields, mtvec modes, FSM encoding and the flag payloads.
package trap_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] EXC_FETCH_MISALIGNED = 4'd0;
    localparam logic [CODE_W-1:0] EXC_ILLEGAL          = 4'd2;
    localparam logic [CODE_W-1:0] EXC_BREAKPOINT       = 4'd3;
    localparam logic [CODE_W-1:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [CODE_W-1:0] EXC_STORE_MISALIGNED = 4'd6;
    localparam logic [CODE_W-1:0] EXC_ECALL_M          = 4'd11;

    localparam logic [CODE_W-1:0] IRQ_SW    = 4'd3;
    localparam logic [CODE_W-1:0] IRQ_TIMER = 4'd7;
    localparam logic [CODE_W-1:0] IRQ_EXT   = 4'd11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam logic [1:0]  PRIV_M         = 2'b11;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_REDIRECT
    } trap_state_e;

    typedef enum logic [2:0] {
        TVAL_ZERO,
        TVAL_FETCH,
        TVAL_INST,
        TVAL_PC,
        TVAL_MEM
    } tval_sel_e;

    typedef struct packed {
        logic fetch_misaligned;
        logic illegal;
        logic ebreak;
        logic ecall;
        logic load_misaligned;
        logic store_misaligned;
    } exc_flags_t;

    typedef struct packed {
        logic ext;
        logic sw;
        logic timer;
    } irq_flags_t;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return r;
    endfunction

    // mret: restore MIE from MPIE and re-arm MPIE.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return r;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder: exception/interrupt flags to
// {take, is_irq, cause code, tval source}. Exceptions always outrank interrupts.
module trap_prio_enc
    import trap_pkg::*;
(
    input  exc_flags_t        exc,
    input  irq_flags_t        irq,
    output logic              take_c,
    output logic              is_irq_c,
    output logic [CODE_W-1:0] cause_c,
    output tval_sel_e         tval_sel_c
);

    always_comb begin
        take_c     = 1'b1;
        is_irq_c   = 1'b0;
        cause_c    = '0;
        tval_sel_c = TVAL_ZERO;
        if (exc.fetch_misaligned) begin
            cause_c    = EXC_FETCH_MISALIGNED;
            tval_sel_c = TVAL_FETCH;
        end else if (exc.illegal) begin
            cause_c    = EXC_ILLEGAL;
            tval_sel_c = TVAL_INST;
        end else if (exc.ebreak) begin
            cause_c    = EXC_BREAKPOINT;
            tval_sel_c = TVAL_PC;
        end else if (exc.ecall) begin
            cause_c    = EXC_ECALL_M;
        end else if (exc.load_misaligned) begin
            cause_c    = EXC_LOAD_MISALIGNED;
            tval_sel_c = TVAL_MEM;
        end else if (exc.store_misaligned) begin
            cause_c    = EXC_STORE_MISALIGNED;
            tval_sel_c = TVAL_MEM;
        end else if (irq.ext) begin
            is_irq_c   = 1'b1;
            cause_c    = IRQ_EXT;
        end else if (irq.sw) begin
            is_irq_c   = 1'b1;
            cause_c    = IRQ_SW;
        end else if (irq.timer) begin
            is_irq_c   = 1'b1;
            cause_c    = IRQ_TIMER;
        end else begin
            take_c     = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises exceptions, sequences trap entry and
// mret (IDLE -> UPDATE -> REDIRECT). Interrupt support is built with TRAP_IRQ_EN.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic            exc_fetch_misaligned_i,
    input  logic            exc_illegal_i,
    input  logic            exc_ebreak_i,
    input  logic            exc_ecall_i,
    input  logic            exc_load_misaligned_i,
    input  logic            exc_store_misaligned_i,
    input  logic [XLEN-1:0] fetch_addr_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mret_i,
`ifdef TRAP_IRQ_EN
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
`endif
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mcause_i,
    output logic            we_exc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic            flush_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_redirect_o,
    output logic            busy_o
);

    trap_state_e       state_q, state_d;
    logic [XLEN-1:0]   target_q, target_d;
    exc_flags_t        exc;
    irq_flags_t        irq_pend;
    logic              take_c, is_irq_c;
    logic [CODE_W-1:0] cause_c;
    tval_sel_e         tval_sel_c;
    logic [XLEN-1:0]   tval, base, trap_target;
    logic              we_d, flush_d, pc_valid_d, busy_d;
    logic [XLEN-1:0]   mcause_d, mepc_d, mtval_d, mstatus_d, pc_redirect_d;
    logic              unused_mie;

    assign exc = '{fetch_misaligned: exc_fetch_misaligned_i,
                   illegal:          exc_illegal_i,
                   ebreak:           exc_ebreak_i,
                   ecall:            exc_ecall_i,
                   load_misaligned:  exc_load_misaligned_i,
                   store_misaligned: exc_store_misaligned_i};

`ifdef TRAP_IRQ_EN
    // An interrupt qualifies only with global MIE and its own enable bit set.
    assign irq_pend.ext   = mstatus_i[MSTATUS_MIE] & irq_ext_i   & mie_i[IRQ_EXT];
    assign irq_pend.sw    = mstatus_i[MSTATUS_MIE] & irq_sw_i    & mie_i[IRQ_SW];
    assign irq_pend.timer = mstatus_i[MSTATUS_MIE] & irq_timer_i & mie_i[IRQ_TIMER];
`else
    assign irq_pend = '0;
`endif
    assign unused_mie = ^mie_i;

    trap_prio_enc u_prio_enc (
        .exc        (exc),
        .irq        (irq_pend),
        .take_c     (take_c),
        .is_irq_c   (is_irq_c),
        .cause_c    (cause_c),
        .tval_sel_c (tval_sel_c)
    );

    always_comb begin
        tval = '0;
        case (tval_sel_c)
            TVAL_FETCH: tval = fetch_addr_i;
            TVAL_INST:  tval = inst_i;
            TVAL_PC:    tval = pc_i;
            TVAL_MEM:   tval = mem_addr_i;
            default:    tval = '0;
        endcase
    end

    // Only interrupts in vectored mode offset the base; modes 2/3 behave as direct.
    assign base        = {mtvec_i[XLEN-1:2], 2'b00};
    assign trap_target = (is_irq_c && mtvec_i[1:0] == MTVEC_VECTORED)
                       ? base + (XLEN'(cause_c) << 2) : base;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        we_d          = 1'b0;
        flush_d       = 1'b0;
        pc_valid_d    = 1'b0;
        busy_d        = 1'b0;
        mcause_d      = '0;
        mepc_d        = '0;
        mtval_d       = '0;
        mstatus_d     = '0;
        pc_redirect_d = RESET_PC;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid_i && take_c) begin
                    state_d   = ST_UPDATE;
                    target_d  = trap_target;
                    we_d      = 1'b1;
                    flush_d   = 1'b1;
                    busy_d    = 1'b1;
                    mcause_d  = is_irq_c ? (32'h8000_0000 | XLEN'(cause_c)) : XLEN'(cause_c);
                    mepc_d    = pc_i;
                    mtval_d   = tval;
                    mstatus_d = trap_mstatus(mstatus_i);
                end else if (inst_valid_i && mret_i) begin
                    state_d   = ST_UPDATE;
                    target_d  = mepc_i;
                    we_d      = 1'b1;
                    flush_d   = 1'b1;
                    busy_d    = 1'b1;
                    mcause_d  = mcause_i;
                    mepc_d    = mepc_i;
                    mstatus_d = mret_mstatus(mstatus_i);
                end
            end
            ST_UPDATE: begin
                state_d       = ST_REDIRECT;
                pc_valid_d    = 1'b1;
                busy_d        = 1'b1;
                pc_redirect_d = target_q;
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            target_q      <= RESET_PC;
            we_exc_o      <= 1'b0;
            flush_o       <= 1'b0;
            pc_valid_o    <= 1'b0;
            busy_o        <= 1'b0;
            mcause_o      <= '0;
            mepc_o        <= '0;
            mtval_o       <= '0;
            mstatus_o     <= '0;
            pc_redirect_o <= RESET_PC;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            we_exc_o      <= we_d;
            flush_o       <= flush_d;
            pc_valid_o    <= pc_valid_d;
            busy_o        <= busy_d;
            mcause_o      <= mcause_d;
            mepc_o        <= mepc_d;
            mtval_o       <= mtval_d;
            mstatus_o     <= mstatus_d;
            pc_redirect_o <= pc_redirect_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception priority, mret, reset abort and
// back-to-back traps; interrupt vectors are added when TRAP_IRQ_EN is defined.
module tb_trap_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk, rst_n;
    logic        inst_valid, mret;
    logic [31:0] pc, inst, fetch_addr, mem_addr;
    logic        e_fetch, e_ill, e_brk, e_ecall, e_ld, e_st;
    logic        irq_sw, irq_timer, irq_ext;
    logic [31:0] mstatus, mie, mtvec, mepc, mcause;
    logic        we_exc, flush, pc_valid, busy;
    logic [31:0] mcause_out, mepc_out, mtval_out, mstatus_out, pc_redirect;

    int checks   = 0;
    int failures = 0;

    trap_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .inst_valid_i           (inst_valid),
        .pc_i                   (pc),
        .inst_i                 (inst),
        .exc_fetch_misaligned_i (e_fetch),
        .exc_illegal_i          (e_ill),
        .exc_ebreak_i           (e_brk),
        .exc_ecall_i            (e_ecall),
        .exc_load_misaligned_i  (e_ld),
        .exc_store_misaligned_i (e_st),
        .fetch_addr_i           (fetch_addr),
        .mem_addr_i             (mem_addr),
        .mret_i                 (mret),
`ifdef TRAP_IRQ_EN
        .irq_sw_i               (irq_sw),
        .irq_timer_i            (irq_timer),
        .irq_ext_i              (irq_ext),
`endif
        .mstatus_i              (mstatus),
        .mie_i                  (mie),
        .mtvec_i                (mtvec),
        .mepc_i                 (mepc),
        .mcause_i               (mcause),
        .we_exc_o               (we_exc),
        .mcause_o               (mcause_out),
        .mepc_o                 (mepc_out),
        .mtval_o                (mtval_out),
        .mstatus_o              (mstatus_out),
        .flush_o                (flush),
        .pc_valid_o             (pc_valid),
        .pc_redirect_o          (pc_redirect),
        .busy_o                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        inst_valid = 1'b0; mret = 1'b0;
        e_fetch = 1'b0; e_ill = 1'b0; e_brk = 1'b0; e_ecall = 1'b0; e_ld = 1'b0; e_st = 1'b0;
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    endtask

    // Inputs for cycle N are already applied; checks N+1 (update), N+2 (redirect), N+3 (idle).
    task automatic run_trap(input string tag, input logic [31:0] cause, input logic [31:0] epc,
                            input logic [31:0] tval, input logic [31:0] mst, input logic [31:0] tgt);
        step();
        clear_flags();
        check({tag, ".we"},      we_exc,      1);
        check({tag, ".flush"},   flush,       1);
        check({tag, ".busy1"},   busy,        1);
        check({tag, ".pcv1"},    pc_valid,    0);
        check({tag, ".mcause"},  mcause_out,  cause);
        check({tag, ".mepc"},    mepc_out,    epc);
        check({tag, ".mtval"},   mtval_out,   tval);
        check({tag, ".mstatus"}, mstatus_out, mst);
        step();
        check({tag, ".we2"},     we_exc,      0);
        check({tag, ".pcv2"},    pc_valid,    1);
        check({tag, ".busy2"},   busy,        1);
        check({tag, ".target"},  pc_redirect, tgt);
        check({tag, ".mcause2"}, mcause_out,  0);
        step();
        check({tag, ".pcv3"},    pc_valid,    0);
        check({tag, ".busy3"},   busy,        0);
        check({tag, ".rstpc3"},  pc_redirect, RST_PC);
    endtask

    initial begin
        clear_flags();
        pc = '0; inst = '0; fetch_addr = '0; mem_addr = '0;
        mstatus = '0; mie = '0; mtvec = '0; mepc = '0; mcause = '0;
        rst_n = 1'b0;
        step();
        step();
        check("rst.we",    we_exc,      0);
        check("rst.busy",  busy,        0);
        check("rst.pcv",   pc_valid,    0);
        check("rst.flush", flush,       0);
        check("rst.pc",    pc_redirect, RST_PC);
        check("rst.mst",   mstatus_out, 0);
        rst_n = 1'b1;
        step();

        // Illegal instruction, direct mode.
        inst_valid = 1; e_ill = 1; mtvec = 32'h100; mstatus = 32'h8; pc = 32'h80; inst = 32'hFFFF_FFFF;
        run_trap("ill", 2, 32'h80, 32'hFFFF_FFFF, 32'h1880, 32'h100);

        // Fetch misaligned beats illegal and ecall; vectored mode ignored for exceptions.
        inst_valid = 1; e_fetch = 1; e_ill = 1; e_ecall = 1;
        mtvec = 32'h201; mstatus = 32'h0; pc = 32'h300; fetch_addr = 32'h123;
        run_trap("fetch", 0, 32'h300, 32'h123, 32'h1800, 32'h200);

        // ebreak, mode 3 treated as direct.
        inst_valid = 1; e_brk = 1; e_ld = 1; mtvec = 32'h103; mstatus = 32'h88; pc = 32'h44;
        run_trap("ebrk", 3, 32'h44, 32'h44, 32'h1880, 32'h100);

        // ecall beats load misaligned; tval is zero.
        inst_valid = 1; e_ecall = 1; e_ld = 1; mtvec = 32'h400; mstatus = 32'h1808;
        pc = 32'h500; mem_addr = 32'h777;
        run_trap("ecall", 11, 32'h500, 0, 32'h1880, 32'h400);

        // Load beats store.
        inst_valid = 1; e_ld = 1; e_st = 1; mtvec = 32'hFFFF_FF00; mstatus = 32'hFFFF_FFFF;
        pc = 32'h8000_0000; mem_addr = 32'hDEAD_BEE1;
        run_trap("load", 4, 32'h8000_0000, 32'hDEAD_BEE1, 32'hFFFF_FFF7, 32'hFFFF_FF00);

        inst_valid = 1; e_st = 1; mtvec = 32'h600; mstatus = 32'h0; pc = 32'h10; mem_addr = 32'h1002;
        run_trap("store", 6, 32'h10, 32'h1002, 32'h1800, 32'h600);

        // mret writes mcause/mepc back unchanged and restores MIE.
        inst_valid = 1; mret = 1; mepc = 32'h200; mstatus = 32'h1880; mcause = 2; pc = 32'h90;
        run_trap("mret", 2, 32'h200, 0, 32'h1888, 32'h200);

        // Exception beats mret.
        inst_valid = 1; mret = 1; e_ill = 1; mepc = 32'h200; mtvec = 32'h100; mstatus = 32'h8;
        pc = 32'hA0; inst = 32'h0000_0013;
        run_trap("mret_ill", 2, 32'hA0, 32'h13, 32'h1880, 32'h100);

        // Unqualified flags are ignored.
        inst_valid = 0; e_ecall = 1; mret = 1;
        step();
        check("nv.we", we_exc, 0);
        check("nv.busy", busy, 0);
        step();
        check("nv.pcv", pc_valid, 0);
        clear_flags();

        // Held ecall: second trap only after REDIRECT.
        inst_valid = 1; e_ecall = 1; mtvec = 32'h100; mstatus = 32'h8; pc = 32'hC0;
        step();
        check("b2b.we1", we_exc, 1);
        step();
        check("b2b.we2", we_exc, 0);
        check("b2b.pcv2", pc_valid, 1);
        step();
        check("b2b.we3", we_exc, 0);
        check("b2b.pcv3", pc_valid, 0);
        step();
        check("b2b.we4", we_exc, 1);
        clear_flags();
        step();
        check("b2b.pcv5", pc_valid, 1);
        step();

        // Reset in UPDATE aborts the sequence.
        inst_valid = 1; e_ill = 1; mtvec = 32'h100; mstatus = 32'h8; pc = 32'h80; inst = 32'h1;
        step();
        clear_flags();
        check("ra.we", we_exc, 1);
        rst_n = 1'b0;
        step();
        check("ra.we0",  we_exc,      0);
        check("ra.pcv0", pc_valid,    0);
        check("ra.mc0",  mcause_out,  0);
        check("ra.pc0",  pc_redirect, RST_PC);
        rst_n = 1'b1;
        step();
        check("ra.pcv1", pc_valid, 0);
        check("ra.busy1", busy, 0);
        inst_valid = 1; e_brk = 1; mtvec = 32'h100; mstatus = 32'h8; pc = 32'h84;
        run_trap("ra.next", 3, 32'h84, 32'h84, 32'h1880, 32'h100);

`ifdef TRAP_IRQ_EN
        // Vectored timer interrupt.
        inst_valid = 1; irq_timer = 1; mtvec = 32'h101; mie = 32'h80; mstatus = 32'h8; pc = 32'h40;
        run_trap("tmr", 32'h8000_0007, 32'h40, 0, 32'h1880, 32'h11C);

        // ecall beats a pending external interrupt.
        inst_valid = 1; e_ecall = 1; irq_ext = 1; mtvec = 32'h101; mie = 32'h800; mstatus = 32'h8; pc = 32'h50;
        run_trap("ecall_irq", 11, 32'h50, 0, 32'h1880, 32'h100);

        // ext > sw > timer.
        inst_valid = 1; irq_ext = 1; irq_sw = 1; irq_timer = 1; mtvec = 32'h101; mie = 32'h888;
        mstatus = 32'h8; pc = 32'h60;
        run_trap("iprio", 32'h8000_000B, 32'h60, 0, 32'h1880, 32'h12C);

        // Global MIE clear: no trap.
        inst_valid = 1; irq_timer = 1; irq_ext = 1; mie = 32'h888; mstatus = 32'h0;
        step();
        check("mask.we", we_exc, 0);
        check("mask.mc", mcause_out, 0);
        step();
        check("mask.pcv", pc_valid, 0);
        clear_flags();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
